sr_data_queue: RTL and testbench

- Hardware FIFO that the CPU's PUSH/POP custom instructions write into and read from.
- PUSH writes the rs1 operand into the queue.
- POP returns the head entry to the register-file write-data mux in the same cycle.
- Single-cycle CPU, so the head is presented combinationally (fall-through read) and pointers update on the clock edge.
- Adds status and sticky error flags for the debug path.

---
 rtl/sr_data_queue.sv | 87 ++++++++
 tb/tb_sr_data_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sr_data_queue.sv
// PUSH/POP instruction queue: fall-through head read, registered pointers and count,
// sticky overflow/underflow flags for the debug path.
module sr_data_queue #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 8,
   localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  writeEnable,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  readEnable,
   output logic [DATA_WIDTH-1:0] readData,
   input  logic                  clear,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic                  w_push_drop;
   logic                  w_pop_fail;

   assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
   assign w_empty = (r_count == '0);

   // A pop in the same cycle frees the slot, so a push into a full queue still lands.
   assign w_push_ok   = writeEnable & (~w_full | readEnable);
   assign w_pop_ok    = readEnable & ~w_empty;
   assign w_push_drop = writeEnable & w_full & ~readEnable;
   assign w_pop_fail  = readEnable & w_empty;

   // Storage carries no reset; validity is governed by count alone.
   always_ff @(posedge clk) begin
      if (!clear && w_push_ok)
         r_mem[r_wr_ptr] <= writeData;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_WIDTH'(w_push_ok) - CNT_WIDTH'(w_pop_ok);
         if (w_push_drop)
            r_overflow <= 1'b1;
         if (w_pop_fail)
            r_underflow <= 1'b1;
      end
   end

   // No bypass: an empty queue reads zero even while a push is in flight.
   assign readData  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_sr_data_queue.sv
// Directed bench for sr_data_queue: ordering, full/empty edges, wrap, simultaneous
// push/pop, clear and asynchronous reset.
module tb_sr_data_queue;

   localparam int DW = 32;
   localparam int DP = 8;
   localparam int CW = $clog2(DP + 1);

   logic          clk;
   logic          reset;
   logic          writeEnable;
   logic [DW-1:0] writeData;
   logic          readEnable;
   logic [DW-1:0] readData;
   logic          clear;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   int n_chk = 0;
   int n_err = 0;

   sr_data_queue #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset),
      .writeEnable(writeEnable), .writeData(writeData),
      .readEnable(readEnable), .readData(readData),
      .clear(clear), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; checks happen in the same window.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      writeEnable = 1'b1;
      writeData   = d;
      tick();
      writeEnable = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
      readEnable = 1'b1;
      #1;
      chk(tag, readData, exp);
      tick();
      readEnable = 1'b0;
   endtask

   initial begin
      reset = 1'b1; writeEnable = 1'b0; writeData = '0; readEnable = 1'b0; clear = 1'b0;
      #12;
      reset = 1'b0;
      tick();

      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_rdata", readData, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);

      // 1: basic ordering
      push(32'h11); push(32'h22); push(32'h33);
      chk("t1_count", count, 3);
      chk("t1_head", readData, 32'h11);
      pop_chk("t1_pop0", 32'h11);
      pop_chk("t1_pop1", 32'h22);
      pop_chk("t1_pop2", 32'h33);
      chk("t1_empty", empty, 1);
      chk("t1_rdata0", readData, 0);

      // 2: fill, overflow drop, drain
      for (int i = 0; i < 8; i++) push(32'(i));
      chk("t2_full", full, 1);
      chk("t2_count", count, 8);
      push(32'hAA);
      chk("t2_ovf", overflow, 1);
      chk("t2_count_after_drop", count, 8);
      chk("t2_head_after_drop", readData, 0);
      for (int i = 0; i < 8; i++) pop_chk($sformatf("t2_pop%0d", i), 32'(i));
      chk("t2_empty", empty, 1);
      chk("t2_ovf_sticky", overflow, 1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("t2_ovf_cleared", overflow, 0);

      // 3: pointer wrap
      for (int i = 0; i < 8; i++) push(32'(i));
      for (int i = 0; i < 5; i++) pop_chk($sformatf("t3_pre%0d", i), 32'(i));
      for (int i = 0; i < 5; i++) push(32'h100 + 32'(i));
      chk("t3_count", count, 8);
      chk("t3_full", full, 1);
      pop_chk("t3_pop5", 32'h5);
      pop_chk("t3_pop6", 32'h6);
      pop_chk("t3_pop7", 32'h7);
      for (int i = 0; i < 5; i++) pop_chk($sformatf("t3_popw%0d", i), 32'h100 + 32'(i));
      chk("t3_empty", empty, 1);

      // 4a: push+pop on full queue
      for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
      writeEnable = 1'b1; writeData = 32'hBB; readEnable = 1'b1;
      #1;
      chk("t4_full_oldhead", readData, 32'h20);
      tick();
      writeEnable = 1'b0; readEnable = 1'b0;
      chk("t4_full_count", count, 8);
      chk("t4_full_ovf", overflow, 0);
      chk("t4_full_newhead", readData, 32'h21);
      for (int i = 1; i < 8; i++) pop_chk($sformatf("t4_drain%0d", i), 32'h20 + 32'(i));
      pop_chk("t4_drain_bb", 32'hBB);
      chk("t4_drained_empty", empty, 1);

      // 4b: push+pop on empty queue
      writeEnable = 1'b1; writeData = 32'hCC; readEnable = 1'b1;
      #1;
      chk("t4_empty_nobypass", readData, 0);
      tick();
      writeEnable = 1'b0; readEnable = 1'b0;
      chk("t4_empty_udf", underflow, 1);
      chk("t4_empty_head", readData, 32'hCC);
      chk("t4_empty_count", count, 1);

      // 5: clear beats a concurrent push
      for (int i = 0; i < 7; i++) push(32'h40 + 32'(i));
      push(32'hEE);
      chk("t5_ovf_set", overflow, 1);
      chk("t5_udf_set", underflow, 1);
      clear = 1'b1; writeEnable = 1'b1; writeData = 32'hDD;
      tick();
      clear = 1'b0; writeEnable = 1'b0;
      chk("t5_count", count, 0);
      chk("t5_empty", empty, 1);
      chk("t5_ovf", overflow, 0);
      chk("t5_udf", underflow, 0);
      chk("t5_rdata", readData, 0);
      tick();
      chk("t5_count_hold", count, 0);
      push(32'h77);
      chk("t5_post_head", readData, 32'h77);
      pop_chk("t5_post_pop", 32'h77);

      // 6: asynchronous reset between edges
      push(32'h1); push(32'h2); push(32'h3);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_empty", empty, 1);
      chk("t6_count", count, 0);
      chk("t6_rdata", readData, 0);
      #1;
      reset = 1'b0;
      tick();
      chk("t6_still_empty", empty, 1);
      push(32'h5);
      chk("t6_head", readData, 32'h5);
      chk("t6_count1", count, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
